// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the bittyCore memory stage (mem_lsu).
// aluop codes, reset level, FSM states and small decode helpers.
package mem_lsu_pkg;

    localparam logic       RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [7:0] EXE_LB  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU = 8'b1110_0101;
    localparam logic [7:0] EXE_SB  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW  = 8'b1110_1011;

    typedef enum logic [0:0] {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_e;

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
    endfunction

    function automatic logic is_mem(input logic [7:0] op);
        return is_store(op) || (op == EXE_LB) || (op == EXE_LH) ||
               (op == EXE_LW) || (op == EXE_LBU) || (op == EXE_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op,
                                           input logic [1:0] a);
        logic half;
        logic word;
        half = (op == EXE_LH) || (op == EXE_LHU) || (op == EXE_SH);
        word = (op == EXE_LW) || (op == EXE_SW);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data bus between the memory stage (master) and the data memory (slave).
// Request is held until ack or err; err takes priority over ack.
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store enables/lane replication and load extraction.
// Without misalign traps, half uses a[1] only and word always uses lane 0.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  be_b;
    logic [3:0]  be_h;

    always_comb begin
        unique case (a_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_b = 4'b0001 << a_i;
        be_h = 4'b0011 << {a_i[1], 1'b0};
    end

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = sdata_i;
        ldata_o = rdata_i;
        unique case (aluop_i)
            EXE_LB: begin
                be_o    = be_b;
                ldata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            EXE_LBU: begin
                be_o    = be_b;
                ldata_o = {24'h0, byte_sel};
            end
            EXE_LH: begin
                be_o    = be_h;
                ldata_o = {{16{half_sel[15]}}, half_sel};
            end
            EXE_LHU: begin
                be_o    = be_h;
                ldata_o = {16'h0, half_sel};
            end
            EXE_LW: be_o = 4'b1111;
            EXE_SB: begin
                be_o    = be_b;
                wdata_o = {4{sdata_i[7:0]}};
            end
            EXE_SH: begin
                be_o    = be_h;
                wdata_o = {2{sdata_i[15:0]}};
            end
            EXE_SW: be_o = 4'b1111;
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// bittyCore memory stage: load/store FSM over the req/ack data bus.
// Optional BITTY_LSU_MISALIGN_EXC_EN traps misaligned half/word accesses.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        stall_req_o,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
`ifdef BITTY_LSU_MISALIGN_EXC_EN
    output logic        misalign_o,
`endif
    output logic        bus_err_o,
    mem_lsu_if.master   dbus
);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic        we_q, we_d;
    logic        valid_q, valid_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic        mem_op;
    logic        misal;
    logic        timeout;
    logic [3:0]  be_c;
    logic [31:0] lane_wdata;
    logic [31:0] ldata;

    mem_lsu_align u_align (
        .aluop_i (aluop_i),
        .a_i     (mem_addr_i[1:0]),
        .sdata_i (mem_sdata_i),
        .rdata_i (dbus.rdata),
        .be_o    (be_c),
        .wdata_o (lane_wdata),
        .ldata_o (ldata)
    );

    assign mem_op = is_mem(aluop_i);
`ifdef BITTY_LSU_MISALIGN_EXC_EN
    assign misal = is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
    assign misal = 1'b0;
`endif
    assign timeout = (state_q == LSU_BUSY) &&
                     (cnt_q == 8'(BUS_TIMEOUT - 1));

    // A trapped misaligned op completes in IDLE, so it must not stall.
    assign stall_req_o = valid_i && mem_op && !misal &&
                         ((state_q == LSU_IDLE) ||
                          (!dbus.ack && !dbus.err && !timeout));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        be_d     = be_q;
        bwdata_d = bwdata_q;
        we_d     = we_q;
        valid_d  = 1'b0;
        wd_d     = wd_i;
        wreg_d   = 1'b0;
        wdata_d  = ZERO_WORD;
        err_d    = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                if (valid_i && mem_op) begin
                    if (misal) begin
                        valid_d = 1'b1;
                    end else begin
                        state_d  = LSU_BUSY;
                        cnt_d    = 8'd0;
                        addr_d   = {mem_addr_i[31:2], 2'b00};
                        be_d     = be_c;
                        bwdata_d = lane_wdata;
                        we_d     = is_store(aluop_i);
                    end
                end else begin
                    valid_d = valid_i;
                    wreg_d  = wreg_i;
                    wdata_d = wdata_i;
                end
            end
            default: begin
                cnt_d = cnt_q + 8'd1;
                if (dbus.err || (timeout && !dbus.ack)) begin
                    state_d = LSU_IDLE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else if (dbus.ack) begin
                    state_d = LSU_IDLE;
                    valid_d = 1'b1;
                    wreg_d  = we_q ? 1'b0 : wreg_i;
                    wdata_d = we_q ? ZERO_WORD : ldata;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q  <= LSU_IDLE;
            cnt_q    <= 8'd0;
            addr_q   <= ZERO_WORD;
            be_q     <= 4'b0000;
            bwdata_q <= ZERO_WORD;
            we_q     <= 1'b0;
            valid_q  <= 1'b0;
            wd_q     <= 5'd0;
            wreg_q   <= 1'b0;
            wdata_q  <= ZERO_WORD;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            bwdata_q <= bwdata_d;
            we_q     <= we_d;
            valid_q  <= valid_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

`ifdef BITTY_LSU_MISALIGN_EXC_EN
    logic mis_q;
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= (state_q == LSU_IDLE) && valid_i && mem_op && misal;
        end
    end
    assign misalign_o = mis_q;
`endif

    assign valid_o    = valid_q;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;
    assign bus_err_o  = err_q;
    assign dbus.req   = (state_q == LSU_BUSY);
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.be    = be_q;
    assign dbus.wdata = bwdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with BUS_TIMEOUT=4.
// Build with BITTY_LSU_MISALIGN_EXC_EN to exercise the misalign trap.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        stall_req_o;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        bus_err_o;
`ifdef BITTY_LSU_MISALIGN_EXC_EN
    logic        misalign_o;
`endif

    int checks   = 0;
    int failures = 0;
    int n;

    mem_lsu_if dbus ();

    mem_lsu #(.BUS_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .aluop_i     (aluop_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sdata_i (mem_sdata_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .stall_req_o (stall_req_o),
        .valid_o     (valid_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
`ifdef BITTY_LSU_MISALIGN_EXC_EN
        .misalign_o  (misalign_o),
`endif
        .bus_err_o   (bus_err_o),
        .dbus        (dbus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] wd);
        valid_i     = 1'b1;
        aluop_i     = op;
        mem_addr_i  = a;
        mem_sdata_i = sd;
        wd_i        = wd;
        wreg_i      = !is_store(op);
        wdata_i     = 32'h0;
    endtask

    task automatic ack_with(input logic [31:0] rd);
        dbus.ack   = 1'b1;
        dbus.rdata = rd;
        tick();
        dbus.ack   = 1'b0;
        valid_i    = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        valid_i     = 1'b0;
        aluop_i     = 8'h00;
        mem_addr_i  = 32'h0;
        mem_sdata_i = 32'h0;
        wd_i        = 5'd0;
        wreg_i      = 1'b0;
        wdata_i     = 32'h0;
        dbus.rdata  = 32'h0;
        dbus.ack    = 1'b0;
        dbus.err    = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(dbus.req), 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'h0);
        rst = 1'b1;

        // non-memory pass-through
        valid_i = 1'b1; aluop_i = 8'h25; wd_i = 5'd5;
        wreg_i  = 1'b1; wdata_i = 32'h1234_5678;
        #1;
        chk("pass_stall", 32'(stall_req_o), 32'd0);
        tick();
        chk("pass_valid", 32'(valid_o), 32'd1);
        chk("pass_wd", 32'(wd_o), 32'd5);
        chk("pass_wreg", 32'(wreg_o), 32'd1);
        chk("pass_wdata", wdata_o, 32'h1234_5678);

        // SW 0x100, ack on the 4th request cycle
        issue(EXE_SW, 32'h100, 32'hDEAD_BEEF, 5'd0);
        #1;
        n = 32'(stall_req_o);
        tick();
        chk("sw_req", 32'(dbus.req), 32'd1);
        chk("sw_we", 32'(dbus.we), 32'd1);
        chk("sw_addr", dbus.addr, 32'h100);
        chk("sw_be", 32'(dbus.be), 32'hF);
        chk("sw_wdata", dbus.wdata, 32'hDEAD_BEEF);
        chk("sw_busy_valid", 32'(valid_o), 32'd0);
        n += 32'(stall_req_o);
        tick();
        n += 32'(stall_req_o);
        tick();
        n += 32'(stall_req_o);
        tick();
        dbus.ack = 1'b1;
        #1;
        chk("sw_ack_stall", 32'(stall_req_o), 32'd0);
        ack_with(32'h0);
        chk("sw_stall_cycles", n, 32'd4);
        chk("sw_valid", 32'(valid_o), 32'd1);
        chk("sw_wreg", 32'(wreg_o), 32'd0);
        chk("sw_req_drop", 32'(dbus.req), 32'd0);

        // LB / LBU at 0x103, back-to-back
        issue(EXE_LB, 32'h103, 32'h0, 5'd7);
        tick();
        chk("lb_be", 32'(dbus.be), 32'h8);
        chk("lb_addr", dbus.addr, 32'h100);
        chk("lb_we", 32'(dbus.we), 32'd0);
        ack_with(32'h8012_3456);
        chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
        chk("lb_wreg", 32'(wreg_o), 32'd1);
        chk("lb_wd", 32'(wd_o), 32'd7);
        issue(EXE_LBU, 32'h103, 32'h0, 5'd8);
        #1;
        chk("lbu_accept_stall", 32'(stall_req_o), 32'd1);
        tick();
        chk("lbu_req", 32'(dbus.req), 32'd1);
        ack_with(32'h8012_3456);
        chk("lbu_wdata", wdata_o, 32'h0000_0080);

        // LH 0x102
        issue(EXE_LH, 32'h102, 32'h0, 5'd9);
        tick();
        chk("lh_be", 32'(dbus.be), 32'hC);
        ack_with(32'h8001_1234);
        chk("lh_wdata", wdata_o, 32'hFFFF_8001);

        // SB 0x102
        issue(EXE_SB, 32'h102, 32'h0000_00A5, 5'd0);
        tick();
        chk("sb_be", 32'(dbus.be), 32'h4);
        chk("sb_wdata", dbus.wdata, 32'hA5A5_A5A5);
        ack_with(32'h0);
        chk("sb_wreg", 32'(wreg_o), 32'd0);

        // timeout after 4 request cycles
        issue(EXE_LW, 32'h200, 32'h0, 5'd3);
        tick();
        n = 0;
        for (int i = 1; i <= 4; i++) begin
            n += 32'(dbus.req);
            chk($sformatf("to_stall_c%0d", i), 32'(stall_req_o),
                (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) tick();
        end
        tick();
        chk("to_req_cycles", n, 32'd4);
        chk("to_req_drop", 32'(dbus.req), 32'd0);
        chk("to_err", 32'(bus_err_o), 32'd1);
        chk("to_valid", 32'(valid_o), 32'd1);
        chk("to_wreg", 32'(wreg_o), 32'd0);
        chk("to_wdata", wdata_o, 32'h0);
        valid_i = 1'b0;
        tick();
        chk("to_err_pulse", 32'(bus_err_o), 32'd0);

        // ack and err together: err wins
        issue(EXE_LW, 32'h300, 32'h0, 5'd4);
        tick();
        dbus.err = 1'b1;
        ack_with(32'h5555_5555);
        dbus.err = 1'b0;
        chk("ae_err", 32'(bus_err_o), 32'd1);
        chk("ae_wreg", 32'(wreg_o), 32'd0);
        chk("ae_wdata", wdata_o, 32'h0);

        // reset while BUSY
        issue(EXE_LW, 32'h400, 32'h0, 5'd6);
        tick();
        chk("rb_req", 32'(dbus.req), 32'd1);
        rst = 1'b0;
        tick();
        chk("rb_req_drop", 32'(dbus.req), 32'd0);
        chk("rb_valid", 32'(valid_o), 32'd0);
        chk("rb_err", 32'(bus_err_o), 32'd0);
        rst     = 1'b1;
        valid_i = 1'b0;
        tick();

        // LW 0x101
        issue(EXE_LW, 32'h101, 32'h0, 5'd10);
`ifdef BITTY_LSU_MISALIGN_EXC_EN
        #1;
        chk("mis_stall", 32'(stall_req_o), 32'd0);
        tick();
        valid_i = 1'b0;
        chk("mis_req", 32'(dbus.req), 32'd0);
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_valid", 32'(valid_o), 32'd1);
        chk("mis_wreg", 32'(wreg_o), 32'd0);
        tick();
        chk("mis_pulse", 32'(misalign_o), 32'd0);
`else
        tick();
        chk("lwu_req", 32'(dbus.req), 32'd1);
        chk("lwu_addr", dbus.addr, 32'h100);
        chk("lwu_be", 32'(dbus.be), 32'hF);
        ack_with(32'hCAFE_F00D);
        chk("lwu_wdata", wdata_o, 32'hCAFE_F00D);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
